irq_request_capture: RTL and testbench

- Upstream stage of the 4-to-2 priority encoder: captures four interrupt request lines, optionally synchronises them, edge-detects and latches them as pending bits, and drives the encoder's `data_in`/`enable`.
- It samples the encoder's 2-bit result and presents it downstream with a valid/ack handshake.
- On ack it clears the serviced pending bit, so lower-priority requests are presented in turn.

---
 rtl/irq_pkg.sv | 16 +
 rtl/irq_sync_edge.sv | 44 ++++
 rtl/irq_request_capture.sv | 85 ++++++++
 tb/tb_irq_request_capture.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types for the interrupt request capture stage: line count, index width,
// presentation FSM states and a one-hot helper.
package irq_pkg;
  localparam int NUM_IRQ  = 4;
  localparam int IRQ_ID_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_SETTLE  = 2'd2
  } irq_state_e;

  function automatic logic [NUM_IRQ-1:0] id_onehot(input logic [IRQ_ID_W-1:0] id);
    return NUM_IRQ'(1) << id;
  endfunction
endpackage

// File: rtl/irq_sync_edge.sv
// One request line: optional two-flop synchroniser (IRQ_SYNC_EN), previous-level
// flop and rising-edge detect. lvl_o is the level seen by the rest of the block.
module irq_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  output logic lvl_o,
  output logic rise_o
);
  logic prev_q, prev_d;

`ifdef IRQ_SYNC_EN
  logic sync1_q, sync1_d, sync2_q, sync2_d;

  always_comb begin
    sync1_d = req_i;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign lvl_o = sync2_q;
`else
  // Source is already synchronous to clk, so it feeds edge detect directly.
  assign lvl_o = req_i;
`endif

  always_comb prev_d = lvl_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  assign rise_o = lvl_o & ~prev_q;
endmodule

// File: rtl/irq_request_capture.sv
// Latches interrupt requests as pending bits, feeds the external 4-to-2 priority
// encoder and presents its result with valid/ack. Optional synchroniser: IRQ_SYNC_EN.
module irq_request_capture
  import irq_pkg::*;
#(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IRQ-1:0]  req_i,
  input  logic [NUM_IRQ-1:0]  mask_i,
  output logic [NUM_IRQ-1:0]  enc_data_o,
  output logic                enc_en_o,
  input  logic [IRQ_ID_W-1:0] enc_code_i,
  output logic                irq_valid_o,
  output logic [IRQ_ID_W-1:0] irq_id_o,
  input  logic                irq_ack_i,
  output logic [NUM_IRQ-1:0]  ovr_o
);
  logic [NUM_IRQ-1:0]  lvl, rise, clr;
  logic [NUM_IRQ-1:0]  pend_q, pend_d, ovr_q, ovr_d;
  logic [IRQ_ID_W-1:0] id_q, id_d;
  irq_state_e          state_q, state_d;
  logic                ack_take;

  irq_sync_edge u_line [NUM_IRQ-1:0] (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req_i),
    .lvl_o  (lvl),
    .rise_o (rise)
  );

  assign enc_data_o  = pend_q & ~mask_i;
  assign enc_en_o    = (state_q == ST_IDLE) && (|enc_data_o);
  assign irq_valid_o = (state_q == ST_PRESENT);
  assign irq_id_o    = id_q;
  assign ovr_o       = ovr_q;

  assign ack_take = (state_q == ST_PRESENT) && irq_ack_i;
  assign clr      = ack_take ? id_onehot(id_q) : '0;

  // A rise on the line being cleared wins and is not an overrun.
  always_comb begin
    pend_d = pend_q;
    ovr_d  = ovr_q;
    if (EDGE_MODE) begin
      pend_d = (pend_q & ~clr) | rise;
      ovr_d  = (ovr_q & ~clr) | (rise & pend_q & ~clr);
    end else begin
      pend_d = lvl & ~clr;
      ovr_d  = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (|enc_data_o) begin
          id_d    = enc_code_i;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: if (irq_ack_i) state_d = ST_SETTLE;
      ST_SETTLE:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      pend_q  <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end
endmodule

// File: tb/tb_irq_request_capture.sv
// Directed plus random bench for irq_request_capture with a behavioural model
// and a reference priority encoder; works with or without IRQ_SYNC_EN.
module tb_irq_request_capture;
`ifdef IRQ_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = '0, mask = '0;
  logic       ack = 1'b0;
  logic [3:0] enc_data_o, ovr_o;
  logic       enc_en_o, irq_valid_o;
  logic [1:0] enc_code, irq_id_o;

  int ntot = 0, nbad = 0;

  // Model state: pending/overrun sets, presentation status, recent request samples.
  logic [3:0] m_pend, m_ovr;
  logic [3:0] hist [0:2];
  logic       m_pres, m_settle;
  logic [1:0] m_id;

  always #5 clk = ~clk;

  function automatic logic [1:0] hi(input logic [3:0] v);
    if (v[3])      return 2'd3;
    else if (v[2]) return 2'd2;
    else if (v[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  always_comb enc_code = enc_en_o ? hi(enc_data_o) : 2'd0;

  irq_request_capture #(.EDGE_MODE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .mask_i(mask),
    .enc_data_o(enc_data_o), .enc_en_o(enc_en_o), .enc_code_i(enc_code),
    .irq_valid_o(irq_valid_o), .irq_id_o(irq_id_o), .irq_ack_i(ack), .ovr_o(ovr_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    assert (got === exp) else begin
      nbad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_ovr = '0; m_pres = 1'b0; m_settle = 1'b0; m_id = '0;
    for (int i = 0; i < 3; i++) hist[i] = '0;
  endtask

  // Advance the model across one clock edge using the inputs present at that edge.
  task automatic model_step();
    logic [3:0] s, ps, rise, clr, enc;
    if (SYNC_LAT == 2) begin s = hist[1]; ps = hist[2]; end
    else               begin s = req;     ps = hist[0]; end
    rise = s & ~ps;
    enc  = m_pend & ~mask;
    clr  = (m_pres && ack) ? (4'b0001 << m_id) : 4'b0000;
    m_ovr  = (m_ovr & ~clr) | (rise & m_pend & ~clr);
    m_pend = (m_pend & ~clr) | rise;
    if (m_settle)       m_settle = 1'b0;
    else if (m_pres) begin
      if (ack) begin m_pres = 1'b0; m_settle = 1'b1; end
    end else if (enc != 4'b0) begin
      m_id = hi(enc); m_pres = 1'b1;
    end
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = req;
  endtask

  task automatic check_all();
    logic [3:0] e;
    e = m_pend & ~mask;
    chk("valid",    32'(irq_valid_o), 32'(m_pres));
    chk("id",       32'(irq_id_o),    32'(m_id));
    chk("ovr",      32'(ovr_o),       32'(m_ovr));
    chk("enc_data", 32'(enc_data_o),  32'(e));
    chk("enc_en",   32'(enc_en_o),    32'(!m_pres && !m_settle && (e != 4'b0)));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic wait_pres(input int bound);
    int n = 0;
    while (!m_pres && n < bound) begin tick(); n++; end
    chk("wait_pres", 32'(irq_valid_o), 32'd1);
  endtask

  task automatic do_ack();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  initial begin
    int n;
    model_reset();
    #2 rst_n = 1'b0;
    #2;
    check_all();
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // Single request on line 2: latency and index.
    req = 4'b0100;
    n = 0;
    do begin tick(); n++; end while (!irq_valid_o && n < 20);
    chk("lat_first", 32'(n), 32'(SYNC_LAT + 2));
    chk("id_line2", 32'(irq_id_o), 32'd2);
    req = 4'b0000;
    tick();
    do_ack();
    repeat (2) tick();

    // Simultaneous lines 3 and 1: priority order, then empty.
    req = 4'b1010; tick(); req = 4'b0000;
    wait_pres(20);
    chk("id_first_3", 32'(irq_id_o), 32'd3);
    do_ack();
    wait_pres(20);
    chk("id_then_1", 32'(irq_id_o), 32'd1);
    do_ack();
    tick();
    chk("enc_empty", 32'(enc_data_o), 32'd0);

    // Overrun on line 1 while it is pending, cleared by its ack.
    req = 4'b0010; tick(); req = 4'b0000;
    wait_pres(20);
    req = 4'b0010; tick(); req = 4'b0000;
    repeat (SYNC_LAT) tick();
    chk("ovr_set", 32'(ovr_o), 32'b0010);
    do_ack();
    chk("ovr_clr", 32'(ovr_o), 32'd0);
    repeat (2) tick();

    // Rise on line 2 in the same cycle its ack clears it.
    req = 4'b0100; tick(); req = 4'b0000;
    wait_pres(20);
    repeat (2) tick();
    req = 4'b0100;
    repeat (SYNC_LAT) tick();
    ack = 1'b1; tick(); ack = 1'b0; req = 4'b0000;
    chk("set_wins", 32'(enc_data_o), 32'b0100);
    wait_pres(20);
    chk("repres_2", 32'(irq_id_o), 32'd2);
    chk("no_ovr2", 32'(ovr_o), 32'd0);
    do_ack();
    repeat (2) tick();

    // Masked line 3 waits until unmasked.
    mask = 4'b1000;
    req = 4'b1001; tick(); req = 4'b0000;
    wait_pres(20);
    chk("mask_id0", 32'(irq_id_o), 32'd0);
    do_ack();
    mask = 4'b0000;
    wait_pres(20);
    chk("unmask_id3", 32'(irq_id_o), 32'd3);
    do_ack();
    repeat (2) tick();

    // Asynchronous reset while presenting, with an overrun outstanding.
    req = 4'b0001; tick(); req = 4'b0000;
    wait_pres(20);
    tick();
    req = 4'b0001; tick(); req = 4'b0000;
    repeat (SYNC_LAT + 1) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(irq_valid_o), 32'd0);
    chk("rst_id", 32'(irq_id_o), 32'd0);
    chk("rst_ovr", 32'(ovr_o), 32'd0);
    chk("rst_enc", 32'(enc_data_o), 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) tick();
    chk("rst_quiet", 32'(irq_valid_o), 32'd0);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 7) == 0) mask = 4'($urandom);
      ack = m_pres ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 4) == 0);
      tick();
    end
    ack = 1'b0; req = 4'b0000;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end
endmodule
